// File: rtl/pacman_pkg.sv
// Shared definitions for the pacman map path: tile codes, map geometry and the
// map-writer state encoding.
package pacman_pkg;

  typedef logic [3:0] tile_t;

  localparam tile_t TILE_EMPTY  = 4'd0;
  localparam tile_t TILE_WALL   = 4'd1;
  localparam tile_t TILE_PILL   = 4'd2;
  localparam tile_t TILE_PACMAN = 4'd3;
  localparam tile_t TILE_GHOST  = 4'd4;

  localparam int MAP_W_DEF = 40;
  localparam int MAP_H_DEF = 30;

  localparam int X_W    = 6;
  localparam int Y_W    = 5;
  localparam int ADDR_W = X_W + Y_W;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_READ  = 3'd1,
    WR_CHECK = 3'd2,
    WR_ERASE = 3'd3,
    WR_DRAW  = 3'd4,
    WR_DONE  = 3'd5
  } wr_state_e;

endpackage

// File: rtl/map_addr_gen.sv
// Tile coordinate to map RAM address ({y, x}) plus out-of-map detection.
// Purely combinational so the renderer can share it.
module map_addr_gen
  import pacman_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              out_of_range
);

  assign addr         = {y, x};
  assign out_of_range = (int'(x) >= MAP_W) || (int'(y) >= MAP_H);

endmodule

// File: rtl/pacman_map_writer.sv
// Map RAM front-end for the pacman location controller: looks up the tile at a
// requested move target, reports it, and moves the pacman tile on open moves.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// WR_IDLE  | waiting for next != curr; latches both coordinate pairs
// WR_READ  | map address = next tile, read in flight
// WR_CHECK | read data valid; capture it (or WALL if off-map) as collision
// WR_ERASE | write EMPTY to the current tile
// WR_DRAW  | write PACMAN to the next tile; count pill if one was there
// WR_DONE  | one-cycle done pulse, collision held for the controller
module pacman_map_writer
  import pacman_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [5:0]  curr_pacman_x,
  input  logic [4:0]  curr_pacman_y,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  output logic [10:0] ram_addr,
  output logic [3:0]  ram_wdata,
  output logic        ram_we,
  input  logic [3:0]  ram_rdata,
  output logic [3:0]  collision_type,
  output logic        done,
  output logic [32:0] pill_count
);

  wr_state_e    state_q, state_d;
  logic [5:0]   cx_q, cx_d, nx_q, nx_d;
  logic [4:0]   cy_q, cy_d, ny_q, ny_d;
  tile_t        coll_q, coll_d;
  logic         done_q, done_d;
  logic         we_q, we_d;
  logic [10:0]  addr_q, addr_d;
  tile_t        wdata_q, wdata_d;
  logic [32:0]  pill_q, pill_d;

  logic [10:0]  next_addr;
  logic         next_oor;

  map_addr_gen #(
    .MAP_W(MAP_W),
    .MAP_H(MAP_H)
  ) u_next_addr (
    .x           (nx_q),
    .y           (ny_q),
    .addr        (next_addr),
    .out_of_range(next_oor)
  );

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    coll_d  = coll_q;
    pill_d  = pill_q;
    case (state_q)
      WR_IDLE: begin
        coll_d = TILE_EMPTY;
        if ((next_pacman_x != curr_pacman_x) || (next_pacman_y != curr_pacman_y)) begin
          cx_d    = curr_pacman_x;
          cy_d    = curr_pacman_y;
          nx_d    = next_pacman_x;
          ny_d    = next_pacman_y;
          state_d = WR_READ;
        end
      end
      WR_READ:  state_d = WR_CHECK;
      WR_CHECK: begin
        // Off-map targets never look at RAM data; they are walls by definition.
        coll_d  = next_oor ? TILE_WALL : ram_rdata;
        state_d = (coll_d == TILE_WALL) ? WR_DONE : WR_ERASE;
      end
      WR_ERASE: state_d = WR_DRAW;
      WR_DRAW: begin
        if (coll_q == TILE_PILL) pill_d = pill_q + 33'd1;
        state_d = WR_DONE;
      end
      WR_DONE: begin
        coll_d  = TILE_EMPTY;
        state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // RAM-side outputs are registered from the next state so they are clean
  // for the whole cycle they belong to.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = (state_d == WR_DONE);
    case (state_d)
      WR_READ:  addr_d = {ny_d, nx_d};
      WR_ERASE: begin
        addr_d  = {cy_q, cx_q};
        wdata_d = TILE_EMPTY;
        we_d    = 1'b1;
      end
      WR_DRAW: begin
        addr_d  = next_addr;
        wdata_d = TILE_PACMAN;
        we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= WR_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      coll_q  <= TILE_EMPTY;
      pill_q  <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= TILE_EMPTY;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      coll_q  <= coll_d;
      pill_q  <= pill_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_addr       = addr_q;
  assign ram_wdata      = wdata_q;
  assign ram_we         = we_q;
  assign collision_type = coll_q;
  assign done           = done_q;
  assign pill_count     = pill_q;

endmodule

// File: tb/tb_pacman_map_writer.sv
// Directed bench for pacman_map_writer with a behavioural single-port map RAM.
module tb_pacman_map_writer;

  logic        clk;
  logic        reset;
  logic [5:0]  cur_x, nxt_x;
  logic [4:0]  cur_y, nxt_y;
  logic [10:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_rdata;
  logic [3:0]  collision_type;
  logic        done;
  logic [32:0] pill_count;

  logic [3:0]  mem [0:2047] = '{default: 4'd0};
  logic        poke_en;
  logic [10:0] poke_addr;
  logic [3:0]  poke_data;
  int          wr_cnt;

  int total = 0;
  int bad   = 0;

  pacman_map_writer dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .curr_pacman_x (cur_x),
    .curr_pacman_y (cur_y),
    .next_pacman_x (nxt_x),
    .next_pacman_y (nxt_y),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_rdata     (ram_rdata),
    .collision_type(collision_type),
    .done          (done),
    .pill_count    (pill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [4:0] y, input logic [5:0] x, input logic [3:0] d);
    poke_en   = 1'b1;
    poke_addr = {y, x};
    poke_data = d;
    cyc();
    poke_en = 1'b0;
  endtask

  task automatic set_pos(input logic [5:0] cx, input logic [4:0] cy,
                         input logic [5:0] nx, input logic [4:0] ny);
    cur_x = cx; cur_y = cy; nxt_x = nx; nxt_y = ny;
  endtask

  int wr0;

  initial begin
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    reset = 1'b1;
    set_pos(6'd20, 5'd20, 6'd20, 5'd20);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_done",  done, 0);
    check("rst_we",    ram_we, 0);
    check("rst_addr",  ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_coll",  collision_type, 0);
    check("rst_pill",  pill_count, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_we",   ram_we, 0);
      check("idle_done", done, 0);
      check("idle_coll", collision_type, 0);
    end

    // Open move into an empty tile: (20,20) -> (20,19)
    poke(5'd19, 6'd20, 4'd0);
    wr0 = wr_cnt;
    set_pos(6'd20, 5'd20, 6'd20, 5'd19);               // cycle 0
    cyc(); check("m1_c1_addr", ram_addr, {5'd19, 6'd20});
           check("m1_c1_we", ram_we, 0);
    cyc(); check("m1_c2_we", ram_we, 0);
           check("m1_c2_done", done, 0);
    cyc(); check("m1_c3_we", ram_we, 1);
           check("m1_c3_addr", ram_addr, {5'd20, 6'd20});
           check("m1_c3_wdata", ram_wdata, 0);
           check("m1_c3_coll", collision_type, 0);
    cyc(); check("m1_c4_we", ram_we, 1);
           check("m1_c4_addr", ram_addr, {5'd19, 6'd20});
           check("m1_c4_wdata", ram_wdata, 3);
           check("m1_c4_done", done, 0);
    cyc(); check("m1_c5_done", done, 1);
           check("m1_c5_we", ram_we, 0);
           check("m1_c5_pill", pill_count, 0);
    set_pos(6'd20, 5'd19, 6'd20, 5'd19);
    cyc(); check("m1_c6_done", done, 0);
           check("m1_c6_coll", collision_type, 0);
    check("m1_mem_old", mem[{5'd20, 6'd20}], 0);
    check("m1_mem_new", mem[{5'd19, 6'd20}], 3);
    check("m1_wr_cnt", wr_cnt - wr0, 2);

    // Open move onto a pill: (20,20) -> (21,20)
    set_pos(6'd20, 5'd20, 6'd20, 5'd20);
    poke(5'd20, 6'd21, 4'd2);
    set_pos(6'd20, 5'd20, 6'd21, 5'd20);
    cyc(); check("m2_c1_addr", ram_addr, {5'd20, 6'd21});
    cyc();
    cyc(); check("m2_c3_coll", collision_type, 2);
    cyc(); check("m2_c4_coll", collision_type, 2);
           check("m2_c4_pill", pill_count, 0);
    cyc(); check("m2_c5_coll", collision_type, 2);
           check("m2_c5_done", done, 1);
           check("m2_c5_pill", pill_count, 1);
    set_pos(6'd21, 5'd20, 6'd21, 5'd20);
    cyc(); check("m2_c6_coll", collision_type, 0);
           check("m2_c6_done", done, 0);

    // Wall: (20,20) -> (19,20); controller collapses next to curr on done
    set_pos(6'd20, 5'd20, 6'd20, 5'd20);
    poke(5'd20, 6'd19, 4'd1);
    wr0 = wr_cnt;
    set_pos(6'd20, 5'd20, 6'd19, 5'd20);
    cyc(); check("w_c1_addr", ram_addr, {5'd20, 6'd19});
    cyc(); check("w_c2_we", ram_we, 0);
           check("w_c2_done", done, 0);
    cyc(); check("w_c3_coll", collision_type, 1);
           check("w_c3_done", done, 1);
           check("w_c3_we", ram_we, 0);
    set_pos(6'd20, 5'd20, 6'd20, 5'd20);
    cyc(); check("w_c4_coll", collision_type, 0);
           check("w_c4_done", done, 0);
    check("w_no_writes", wr_cnt - wr0, 0);
    check("w_mem", mem[{5'd20, 6'd19}], 1);

    // Off-map x=45 over a PILL byte: still a wall; then back-to-back request
    poke(5'd20, 6'd45, 4'd2);
    poke(5'd21, 6'd20, 4'd0);
    wr0 = wr_cnt;
    set_pos(6'd20, 5'd20, 6'd45, 5'd20);
    cyc(); cyc();
    cyc(); check("oor_c3_coll", collision_type, 1);
           check("oor_c3_done", done, 1);
           check("oor_c3_we", ram_we, 0);
    set_pos(6'd20, 5'd20, 6'd20, 5'd21);               // new cycle 0 is next
    cyc(); check("oor_c4_coll", collision_type, 0);
           check("oor_no_writes", wr_cnt - wr0, 0);
           check("oor_pill", pill_count, 1);
    cyc(); check("b2b_c1_addr", ram_addr, {5'd21, 6'd20});
    cyc(); cyc();
           check("b2b_c3_we", ram_we, 1);
    cyc(); cyc();
           check("b2b_c5_done", done, 1);
    set_pos(6'd20, 5'd21, 6'd20, 5'd21);
    cyc();

    // Reset during DRAW; next changed during READ must not move the target
    set_pos(6'd20, 5'd20, 6'd20, 5'd20);
    poke(5'd20, 6'd22, 4'd2);
    set_pos(6'd20, 5'd20, 6'd22, 5'd20);
    cyc(); check("r_c1_addr", ram_addr, {5'd20, 6'd22});
    nxt_x = 6'd5; nxt_y = 5'd5;
    cyc();
    cyc(); check("r_c3_addr", ram_addr, {5'd20, 6'd20});
    cyc(); check("r_c4_addr", ram_addr, {5'd20, 6'd22});
           check("r_c4_we", ram_we, 1);
    reset = 1'b1;
    set_pos(6'd20, 5'd20, 6'd20, 5'd20);
    cyc(); check("r_after_we", ram_we, 0);
           check("r_after_pill", pill_count, 0);
           check("r_after_done", done, 0);
           check("r_after_coll", collision_type, 0);
    reset = 1'b0;
    wr0 = wr_cnt;
    cyc(); cyc(); cyc();
    check("r_idle_done", done, 0);
    check("r_idle_writes", wr_cnt - wr0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pacman_map_writer.md
# pacman_map_writer

- Responder to the pacman location controller.
- Detects a pending move (next position ≠ current position) and reads the destination tile from the game-map RAM. It reports that tile as `collision_type`.
- On a non-wall move, it erases pacman at the current tile and draws him at the next tile, then pulses `done` so the controller commits the move.
- Sits between the location controller and the single-port map RAM that also feeds the VGA renderer.

## Interface
Parameters:
- `MAP_W`, 40: map width in tiles; x ≥ `MAP_W` is out of range.
- `MAP_H`, 30: map height in tiles; y ≥ `MAP_H` is out of range.

Ports:
- `CLOCK_50`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `curr_pacman_x`  in  6  current x from location controller.
- `curr_pacman_y`  in  5  current y.
- `next_pacman_x`  in  6  requested x.
- `next_pacman_y`  in  5  requested y.
- `ram_addr`  out  11  map RAM address = {y, x}.
- `ram_wdata`  out  4  tile code to write.
- `ram_we`  out  1  write enable.
- `ram_rdata`  in  4  tile code read; valid one cycle after `ram_addr` is sampled.
- `collision_type`  out  4  tile code at the requested position; `TILE_EMPTY` when idle.
- `done`  out  1  one-cycle pulse; the move is finished (or rejected).
- `pill_count`  out  33  pills eaten since reset.

Decided: one clock `CLOCK_50`; `reset` is synchronous and active-high.

## Operation
Tile codes: `TILE_EMPTY`=0, `TILE_WALL`=1, `TILE_PILL`=2, `TILE_PACMAN`=3, `TILE_GHOST`=4.

States: IDLE → READ → CHECK → {ERASE → DRAW →} DONE → IDLE.
- **IDLE**
  - If next ≠ curr: latch curr and next into `cx`, `cy`, `nx`, `ny`; go to READ. Otherwise stay.
  - `collision_type` = `TILE_EMPTY`.
- **READ**
  - `ram_addr` = {`ny`, `nx`}, `ram_we` = 0.
- **CHECK**
  - `ram_rdata` is valid. Register it into `collision_type`.
  - If `nx` ≥ `MAP_W` or `ny` ≥ `MAP_H`, register `TILE_WALL` instead of the RAM data.
  - If the registered value is `TILE_WALL` → DONE; otherwise → ERASE.
- **ERASE**
  - `ram_addr` = {`cy`, `cx`}, `ram_wdata` = `TILE_EMPTY`, `ram_we` = 1.
- **DRAW**
  - `ram_addr` = {`ny`, `nx`}, `ram_wdata` = `TILE_PACMAN`, `ram_we` = 1.
  - If `collision_type` == `TILE_PILL`, increment `pill_count` (wraps at 2^33).
- **DONE**
  - `done` = 1. `collision_type` is held.
  - Next state is IDLE; `collision_type` is cleared to `TILE_EMPTY` on that transition.

Rules:
- `TILE_GHOST` does not block the move. It is only reported on `collision_type`; game-over logic acts on it elsewhere.
- Inputs are ignored outside IDLE. A controller that changes `next_*` mid-operation (it collapses next to curr on a wall) does not disturb the latched coordinates.
- `ram_we` is 0 in every state except ERASE and DRAW.
- All RAM outputs are decoded from state plus latched registers (Moore), glitch-free.
- The initial pacman tile at (20,20) is part of the map init image; this block does not draw it.

## Timing
- Cycle 0 = IDLE with next ≠ curr.
- Wall / out-of-range path:
  - `collision_type` = WALL from cycle 3.
  - `done` = 1 in cycle 3.
  - Cycle 4 is IDLE, `collision_type` = EMPTY.
  - The controller sees WALL and `done` together, so it commits curr = curr.
- Open path:
  - `collision_type` valid from cycle 3.
  - ERASE write in cycle 3, DRAW write in cycle 4.
  - `done` = 1 in cycle 5; IDLE in cycle 6.
- Back-to-back moves: a new request seen in cycle 6 (wall path: cycle 4) starts immediately.
- `done` never lasts more than one cycle and never occurs outside the DONE state.
- Reset values: state IDLE, `done` 0, `ram_we` 0, `ram_addr` 0, `ram_wdata` `TILE_EMPTY`, `collision_type` `TILE_EMPTY`, `pill_count` 0, latches 0.
- Reset in any state, including mid-write: the next cycle is IDLE with no write. A half-finished erase/draw is not completed; the map is re-initialised alongside.

## Structure
- Shared package `pacman_pkg`:
  - tile-code constants and `tile_t` (4-bit);
  - `MAP_W`/`MAP_H` defaults;
  - writer state enum.
- The location controller should import the same `TILE_WALL` constant.
- Optional sub-module `map_addr_gen`: combinational range check plus {y, x} concatenation, shared with the renderer. Otherwise the block is flat.

## Test plan
- Reset, curr = next = (20,20) held 10 cycles → `ram_we` never 1, `done` never 1, `collision_type` = 0.
- Next = (20,19), RAM (20,19) = EMPTY:
  - cycle 1 `ram_addr` = {19,20};
  - cycle 3 write EMPTY at {20,20};
  - cycle 4 write PACMAN at {19,20};
  - cycle 5 `done`; `pill_count` stays 0.
- Next = (21,20), RAM holds PILL → `collision_type` = 2 in cycles 3–5, `pill_count` 0 → 1 after cycle 4, `done` in cycle 5.
- Next = (19,20), RAM holds WALL → `collision_type` = 1 and `done` in cycle 3, no writes; `collision_type` = 0 in cycle 4.
- Next x = 45 (out of range) → treated as WALL with no RAM-data dependence; `done` in cycle 3.
- Reset asserted in the DRAW cycle → next cycle IDLE, `ram_we` 0, `pill_count` 0. `next_*` changed during READ → latched address is unchanged.
